multicycle_cu: RTL and testbench

Multi-cycle control sequencer for the 2-bit-opcode datapath (R-format, ADDI, LW, SW). It replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. Memory accesses use a request/ready handshake with a shared instruction/data memory. It sits between the instruction register and the datapath muxes, the register file, the ALU control and the memory port.

---
 rtl/multicycle_cu.sv | 174 +++++++++++++++++
 tb/tb_multicycle_cu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control sequencer for the 2-bit-opcode datapath.
// Steps each instruction through fetch, decode, execute, memory and
// write-back, and handshakes with a shared instruction/data memory
// through mem_req/mem_ready.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for run; all strobes low
//   FETCH  | instruction read at PC; IR/PC load in the ready cycle
//   DECODE | opcode latched into op_q
//   EXEC   | ALU operation for the latched opcode
//   MEM    | data read (LW) or write (SW) at ALU result
//   WB     | register-file write-back; instruction retires
module multicycle_cu #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUOp,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  state_t           cur_state;
  state_t           nxt_state;
  logic [1:0]       op_q;
  logic             instr_end;
  logic [CNT_W-1:0] count_q;

  // State register; reset lands in IDLE so every Moore output drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Opcode is captured only in DECODE; later IR changes cannot redirect
  // an instruction already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_R;
    end else if (cur_state == ST_DECODE) begin
      op_q <= opcode;
    end
  end

  // Retired-instruction counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (instr_end) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Next-state and strobe decode. Only IRWrite/PCWrite and the SW retire
  // pulse look at mem_ready; everything else is a function of state/op_q.
  always_comb begin
    nxt_state = cur_state;
    instr_end = 1'b0;
    mem_req   = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUOp     = 1'b0;

    case (cur_state)
      ST_IDLE: begin
        if (run) begin
          nxt_state = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nxt_state = ST_DECODE;
        end
      end

      ST_DECODE: begin
        nxt_state = ST_EXEC;
      end

      ST_EXEC: begin
        ALUSrc = (op_q != OP_R);
        ALUOp  = (op_q == OP_R) || (op_q == OP_ADDI);
        if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          nxt_state = ST_MEM;
        end else begin
          nxt_state = ST_WB;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        ALUSrc  = 1'b1;
        if (op_q == OP_SW) begin
          MemWrite = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            instr_end = 1'b1;
          end else begin
            nxt_state = ST_WB;
          end
        end
      end

      ST_WB: begin
        RegWrite  = 1'b1;
        RegDst    = (op_q == OP_R);
        MemToReg  = (op_q == OP_LW);
        instr_end = 1'b1;
      end

      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    // Retirement: continue straight into the next fetch while run is held.
    if (instr_end) begin
      nxt_state = run ? ST_FETCH : ST_IDLE;
    end
  end

  assign state       = cur_state;
  assign instr_done  = instr_end;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu (CNT_W = 4 so the counter wrap is reachable).
// Inputs are driven and outputs sampled around the falling edge.
module tb_multicycle_cu;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [1:0]    opcode;
  logic          mem_ready;
  logic          mem_req, IorD, IRWrite, PCWrite, RegDst, ALUSrc;
  logic          MemToReg, RegWrite, MemRead, MemWrite, ALUOp;
  logic [2:0]    state;
  logic          instr_done;
  logic [CW-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  // Bit order: mem_req IorD IRWrite PCWrite RegDst ALUSrc MemToReg RegWrite MemRead MemWrite ALUOp instr_done
  logic [11:0] strobes;
  assign strobes = {mem_req, IorD, IRWrite, PCWrite, RegDst, ALUSrc,
                    MemToReg, RegWrite, MemRead, MemWrite, ALUOp, instr_done};

  localparam logic [11:0] S_ZERO   = 12'b0000_0000_0000;
  localparam logic [11:0] S_FWAIT  = 12'b1000_0000_1000;
  localparam logic [11:0] S_FRDY   = 12'b1011_0000_1000;
  localparam logic [11:0] S_EX_R   = 12'b0000_0000_0010;
  localparam logic [11:0] S_EX_AI  = 12'b0000_0100_0010;
  localparam logic [11:0] S_EX_LS  = 12'b0000_0100_0000;
  localparam logic [11:0] S_MEM_LW = 12'b1100_0100_1000;
  localparam logic [11:0] S_MEM_SW = 12'b1100_0100_0100;
  localparam logic [11:0] S_SW_RET = 12'b1100_0100_0101;
  localparam logic [11:0] S_WB_R   = 12'b0000_1001_0001;
  localparam logic [11:0] S_WB_AI  = 12'b0000_0001_0001;
  localparam logic [11:0] S_WB_LW  = 12'b0000_0011_0001;

  multicycle_cu #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .state(state),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; opcode = 2'b00; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++;
    if (state !== 3'd0 || strobes !== S_ZERO) begin
      n_err++;
      $display("FAIL reset_outputs: state=%0d strobes=%b, expected state=0 strobes=%b", state, strobes, S_ZERO);
    end
    n_cmp++;
    if (instr_count !== 4'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d, expected 0", instr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL reset_release: state=%0d, expected 1", state);
    end
  endtask

  task automatic test_rformat();
    logic [2:0]  es [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [11:0] eo [4] = '{S_FRDY, S_ZERO, S_EX_R, S_WB_R};
    opcode = 2'b00; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (state !== es[i] || strobes !== eo[i]) begin
        n_err++;
        $display("FAIL rformat cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b", i, state, strobes, es[i], eo[i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (state !== 3'd1 || instr_count !== 4'd1) begin
      n_err++;
      $display("FAIL rformat_retire: state=%0d count=%0d, expected state=1 count=1", state, instr_count);
    end
  endtask

  task automatic test_lw_waits();
    logic        rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  es  [10] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    logic [11:0] eo  [10] = '{S_FWAIT, S_FWAIT, S_FRDY, S_ZERO, S_EX_LS,
                              S_MEM_LW, S_MEM_LW, S_MEM_LW, S_MEM_LW, S_WB_LW};
    opcode = 2'b10; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      n_cmp++;
      if (state !== es[i] || strobes !== eo[i]) begin
        n_err++;
        $display("FAIL lw cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b", i, state, strobes, es[i], eo[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    n_cmp++;
    if (state !== 3'd1 || instr_count !== 4'd2) begin
      n_err++;
      $display("FAIL lw_retire: state=%0d count=%0d, expected state=1 count=2", state, instr_count);
    end
  endtask

  task automatic test_sw();
    logic [2:0]  es [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [11:0] eo [4] = '{S_FRDY, S_ZERO, S_EX_LS, S_SW_RET};
    opcode = 2'b11; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (state !== es[i] || strobes !== eo[i]) begin
        n_err++;
        $display("FAIL sw cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b", i, state, strobes, es[i], eo[i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (state !== 3'd1 || instr_count !== 4'd3) begin
      n_err++;
      $display("FAIL sw_retire: state=%0d count=%0d, expected state=1 count=3", state, instr_count);
    end
  endtask

  task automatic test_opcode_ignored();
    logic [1:0]  op [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
    logic [2:0]  es [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [11:0] eo [4] = '{S_FRDY, S_ZERO, S_EX_AI, S_WB_AI};
    mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = op[i];
      #1;
      n_cmp++;
      if (state !== es[i] || strobes !== eo[i]) begin
        n_err++;
        $display("FAIL addi_opchg cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b", i, state, strobes, es[i], eo[i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (instr_count !== 4'd4) begin
      n_err++;
      $display("FAIL addi_count: got %0d, expected 4", instr_count);
    end
  endtask

  task automatic test_run_drop_and_wrap();
    logic        rn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  es [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [11:0] eo [4] = '{S_FRDY, S_ZERO, S_EX_R, S_WB_R};
    opcode = 2'b00; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = rn[i];
      #1;
      n_cmp++;
      if (state !== es[i] || strobes !== eo[i]) begin
        n_err++;
        $display("FAIL rundrop cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b", i, state, strobes, es[i], eo[i]);
      end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd0 || strobes !== S_ZERO || instr_count !== 4'd5) begin
      n_err++;
      $display("FAIL rundrop_idle: state=%0d strobes=%b count=%0d, expected state=0 strobes=0 count=5", state, strobes, instr_count);
    end
    run = 1'b1;
    @(negedge clk);
    // 11 back-to-back R-format instructions: count 5 -> 16, wrapping to 0.
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          n_cmp++;
          if (state !== 3'd1) begin
            n_err++;
            $display("FAIL b2b_fetch instr%0d: state=%0d, expected 1", k, state);
          end
        end
        if (c == 3) begin
          if (k == 10) run = 1'b0;
          #1;
          n_cmp++;
          if (state !== 3'd5 || instr_done !== 1'b1 || instr_count !== 4'(5 + k)) begin
            n_err++;
            $display("FAIL b2b_wb instr%0d: state=%0d done=%b count=%0d, expected state=5 done=1 count=%0d", k, state, instr_done, instr_count, 4'(5 + k));
          end
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    if (state !== 3'd0 || instr_count !== 4'd0) begin
      n_err++;
      $display("FAIL wrap: state=%0d count=%0d, expected state=0 count=0", state, instr_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    opcode = 2'b11; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd4 || MemWrite !== 1'b1) begin
      n_err++;
      $display("FAIL rstmem_pre: state=%0d MemWrite=%b, expected state=4 MemWrite=1", state, MemWrite);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || strobes !== S_ZERO) begin
      n_err++;
      $display("FAIL rstmem_async: state=%0d strobes=%b, expected state=0 strobes=0", state, strobes);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd0 || strobes !== S_ZERO || instr_count !== 4'd0) begin
      n_err++;
      $display("FAIL rstmem_post: state=%0d strobes=%b count=%0d, expected state=0 strobes=0 count=0", state, strobes, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_rformat();
    test_lw_waits();
    test_sw();
    test_opcode_ignored();
    test_run_drop_and_wrap();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
